// File: rtl/alu_issue_control.sv
// alu_issue_control
// Pipeline controller between decode and the ALU execute stage. Each cycle
// it decides whether the decoded instruction issues, is held back by a data
// hazard or an in-flight multiply, or is squashed by a taken branch/JALR
// reported from the ALU stage.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   issue_valid/alu_operation/...   decoded instruction and its source regs
//   ex_dest_*, wb_dest_*            pending destinations for hazard detection
//   alu_out_branch_*                taken-branch report from the ALU stage
//   stall_fetch, stall_decode       hold PC and decode register
//   flush_decode                    replace decode contents with a NOP
//   alu_issue/alu_hold/alu_bubble   ALU input register load control (one-hot)
//   alu_dest_enable_mask            gates the ALU destination write enable
//   pc_redirect(_address)           load PC with the branch target
module alu_issue_control #(
  parameter int         MUL_LATENCY = 3,
  parameter int         FLUSH_DEPTH = 2,
  parameter logic [4:0] MUL_OPCODE  = 5'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_alu_operation,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_uses_rs1,
  input  logic        issue_uses_rs2,
  input  logic        ex_dest_enable,
  input  logic [4:0]  ex_dest_register,
  input  logic        wb_dest_enable,
  input  logic [4:0]  wb_dest_register,
  input  logic        alu_out_branch_enable,
  input  logic [31:0] alu_out_branch_address,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        flush_decode,
  output logic        alu_issue,
  output logic        alu_hold,
  output logic        alu_bubble,
  output logic        alu_dest_enable_mask,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_address
);

  typedef enum logic [1:0] {RUN, MUL_BUSY, FLUSH} state_t;

  // Counter reload values; clamped so an out-of-use path never underflows.
  localparam int         MUL_RELOAD_INT   = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam int         FLUSH_RELOAD_INT = (FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 1 : 0;
  localparam logic [3:0] MUL_RELOAD       = 4'(MUL_RELOAD_INT);
  localparam logic [2:0] FLUSH_RELOAD     = 3'(FLUSH_RELOAD_INT);
  localparam state_t     REDIRECT_TARGET  = (FLUSH_DEPTH > 1) ? FLUSH : RUN;

  state_t     state, next_state;
  logic [3:0] mul_count, next_mul_count;
  logic [2:0] flush_count, next_flush_count;
  logic       rs1_hit, rs2_hit, hazard;

  // x0 is hard-wired zero, so a write to it can never create a dependency.
  always_comb begin
    rs1_hit = issue_uses_rs1 && (issue_rs1 != 5'd0) &&
              ((ex_dest_enable && (ex_dest_register == issue_rs1)) ||
               (wb_dest_enable && (wb_dest_register == issue_rs1)));
    rs2_hit = issue_uses_rs2 && (issue_rs2 != 5'd0) &&
              ((ex_dest_enable && (ex_dest_register == issue_rs2)) ||
               (wb_dest_enable && (wb_dest_register == issue_rs2)));
    hazard  = issue_valid && (rs1_hit || rs2_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      mul_count   <= 4'd0;
      flush_count <= 3'd0;
    end else begin
      state       <= next_state;
      mul_count   <= next_mul_count;
      flush_count <= next_flush_count;
    end
  end

  always_comb begin
    next_state           = state;
    next_mul_count       = mul_count;
    next_flush_count     = flush_count;
    stall_fetch          = 1'b0;
    stall_decode         = 1'b0;
    flush_decode         = 1'b0;
    alu_issue            = 1'b0;
    alu_hold             = 1'b0;
    alu_bubble           = 1'b0;
    alu_dest_enable_mask = 1'b0;
    pc_redirect          = 1'b0;
    pc_redirect_address  = 32'd0;

    // A taken branch wins in every state; in MUL_BUSY it kills the multiply
    // by bubbling the ALU inputs with the write mask left low.
    if (alu_out_branch_enable) begin
      pc_redirect         = 1'b1;
      pc_redirect_address = alu_out_branch_address;
      flush_decode        = 1'b1;
      alu_bubble          = 1'b1;
      next_flush_count    = FLUSH_RELOAD;
      next_state          = REDIRECT_TARGET;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            alu_bubble   = 1'b1;
          end else if (issue_valid && (issue_alu_operation == MUL_OPCODE)) begin
            alu_issue = 1'b1;
            if (MUL_LATENCY > 1) begin
              next_mul_count = MUL_RELOAD;
              next_state     = MUL_BUSY;
            end else begin
              alu_dest_enable_mask = 1'b1;
            end
          end else if (issue_valid) begin
            alu_issue            = 1'b1;
            alu_dest_enable_mask = 1'b1;
          end else begin
            alu_bubble = 1'b1;
          end
        end
        // The multiplier result is written only in its final busy cycle.
        MUL_BUSY: begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          alu_hold     = 1'b1;
          if (mul_count == 4'd0) begin
            alu_dest_enable_mask = 1'b1;
            next_state           = RUN;
          end else begin
            next_mul_count = mul_count - 4'd1;
          end
        end
        FLUSH: begin
          flush_decode     = 1'b1;
          alu_bubble       = 1'b1;
          next_flush_count = (flush_count == 3'd0) ? 3'd0 : flush_count - 3'd1;
          if (flush_count <= 3'd1) begin
            next_state = RUN;
          end
        end
        default: begin
          alu_bubble = 1'b1;
          next_state = RUN;
        end
      endcase
    end

    // While reset is held the outputs show their idle values regardless of
    // inputs, so nothing leaks out of an aborted multiply or redirect.
    if (reset) begin
      stall_fetch          = 1'b0;
      stall_decode         = 1'b0;
      flush_decode         = 1'b0;
      alu_issue            = 1'b0;
      alu_hold             = 1'b0;
      alu_bubble           = 1'b1;
      alu_dest_enable_mask = 1'b0;
      pc_redirect          = 1'b0;
      pc_redirect_address  = 32'd0;
    end
  end

endmodule

// File: doc/alu_issue_control.md
# alu_issue_control

Pipeline controller sitting between decode and the ALU execute stage. It decides, every cycle, whether the decoded instruction issues into the ALU, is held by a data hazard or a multi-cycle multiply, or is squashed by a taken branch/JALR reported by the ALU stage. It drives the stall, flush, bubble and PC-redirect controls for fetch, decode and the ALU input registers.

## Interface
Parameters:
- MUL_LATENCY, 3: cycles a MULTIPLICATION occupies the ALU (legal range 1..15).
- FLUSH_DEPTH, 2: cycles of decode flush after a redirect (legal range 1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_alu_operation  in  5  ALU opcode of that instruction (ALU_constants.vinc encoding).
- issue_rs1, issue_rs2  in  5 each  source register numbers; x0 never causes a hazard.
- issue_uses_rs1, issue_uses_rs2  in  1 each  source actually read.
- ex_dest_enable, ex_dest_register  in  1 / 5  destination currently registered at the ALU stage output.
- wb_dest_enable, wb_dest_register  in  1 / 5  destination in writeback, not yet in the register file.
- alu_out_branch_enable, alu_out_branch_address  in  1 / 32  taken-branch report from the ALU stage.
- stall_fetch, stall_decode  out  1 each  hold PC and decode register.
- flush_decode  out  1  replace decode contents with a NOP.
- alu_issue  out  1  load ALU input registers from decode this cycle.
- alu_hold  out  1  ALU input registers keep their value.
- alu_bubble  out  1  ALU input registers load a NOP (operation 0, dest enable FALSE).
- alu_dest_enable_mask  out  1  AND-ed into ALU in_dest_register_enable.
- pc_redirect, pc_redirect_address  out  1 / 32  load PC with the address.

## Operation
- FSM states: RUN, MUL_BUSY, FLUSH. Reset state RUN; mul and flush counters reset to 0.
- hazard = issue_valid and, for each used non-x0 source, a match against ex_dest_register (ex_dest_enable) or wb_dest_register (wb_dest_enable).
- RUN:
  - Taken branch (alu_out_branch_enable=1) has top priority: pc_redirect=1, flush_decode=1, alu_bubble=1, flush counter=FLUSH_DEPTH-1; to FLUSH if FLUSH_DEPTH>1, else remain RUN.
  - Else hazard: stall_fetch=stall_decode=1, alu_bubble=1.
  - Else issue_valid and operation MULTIPLICATION: alu_issue=1, alu_dest_enable_mask=0; if MUL_LATENCY>1 go MUL_BUSY with mul counter=MUL_LATENCY-2, else mask=1 and stay RUN.
  - Else issue_valid: alu_issue=1, mask=1. Else alu_bubble=1.
- MUL_BUSY: stall_fetch=stall_decode=1, alu_hold=1, mask=0 while counter>0; at counter 0 mask=1 (single result write) and return to RUN. Counter decrements each cycle.
  - Taken branch in MUL_BUSY kills the multiply: redirect, flush, alu_bubble=1 (alu_hold=0), mask=0, go FLUSH (or RUN if FLUSH_DEPTH=1).
- FLUSH: flush_decode=1, alu_bubble=1, fetch runs (stall_fetch=0); counter decrements; leave to RUN when counter reaches 0 at that edge. A second taken branch here is impossible (only bubbles issued); if seen, treat as a fresh redirect and reload the counter.
- Exactly one of alu_issue, alu_hold, alu_bubble is 1 every cycle out of reset.

## Timing
- Reset values: stall_fetch=stall_decode=0, flush_decode=0, alu_issue=0, alu_hold=0, alu_bubble=1, alu_dest_enable_mask=0, pc_redirect=0, pc_redirect_address=0.
- All outputs combinational from state and inputs; no input-to-state latency beyond one edge.
- Taken branch reported at cycle T: redirect and flush in T, flush continues T+1..T+FLUSH_DEPTH-1, first new instruction may issue at T+FLUSH_DEPTH.
- Multiply issued at T: ALU busy T+1..T+MUL_LATENCY-1, result written once; next issue at T+MUL_LATENCY.
- Reset asserted mid-MUL_BUSY or FLUSH: return to RUN immediately; no pending redirect survives.

## Test plan
- Reset in MUL_BUSY: outputs go to reset values asynchronously; after release, plain ADDITION issues next cycle with alu_issue=1.
- Back-to-back ADDITIONs, no hazards: alu_issue=1 every cycle, stalls 0, mask=1.
- ADDITION x5 then SUBTRACTION reading x5: SUBTRACTION stalled 2 cycles (ex then wb match), issues third cycle; reading x0 never stalls.
- MULTIPLICATION with MUL_LATENCY=3: alu_issue cycle T, alu_hold T+1..T+2, mask=1 only at T+2, following instruction issues T+3.
- Taken BEQ reported with address 0x40, FLUSH_DEPTH=2: pc_redirect=1 with 0x40 one cycle, flush_decode 2 cycles, issue resumes cycle 3.
- Branch reported during MUL_BUSY: multiply killed (mask never 1), redirect to reported address, FSM enters FLUSH.
